// File: rtl/wb_pwm_leds_pkg.sv
// Shared types and register-layout constants for the Wishbone PWM LED block.
package wb_pwm_leds_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_PWM   = 2'b10,
      MODE_BLINK = 2'b11
   } mode_t;

   localparam int CTRL_OFS  = 0;
   localparam int EN_BIT    = 0;
   localparam int PRESC_LSB = 8;
   localparam int DUTY_W    = 8;
   localparam int MODE_LSB  = 8;

endpackage

// File: rtl/wb_pwm_chan.sv
// One LED channel: programmed duty/mode, shadowed active duty, registered LED drive.
module wb_pwm_chan
   import wb_pwm_leds_pkg::*;
(
   input  logic                  clk_sys,
   input  logic                  rst_b,
   input  logic                  wr,
   input  logic [1:0]            sel,
   input  logic [MODE_LSB+1:0]   dat,
   input  logic [DUTY_W-1:0]     pwm_cnt,
   input  logic                  wrap,
   input  logic                  blink,
   input  logic                  en,
   output logic [MODE_LSB+1:0]   rdata,
   output logic                  led
);

   logic [DUTY_W-1:0] duty;
   logic [DUTY_W-1:0] duty_act;
   mode_t             mode;

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         duty     <= '0;
         duty_act <= '0;
         mode     <= MODE_OFF;
         led      <= 1'b0;
      end else begin
         if (wr && sel[0]) duty <= dat[DUTY_W-1:0];
         if (wr && sel[1]) mode <= mode_t'(dat[MODE_LSB +: 2]);
         // active duty only moves at a period boundary so a period is never split
         if (wrap || !en) duty_act <= duty;
         if (!en) begin
            led <= 1'b0;
         end else begin
            case (mode)
               MODE_OFF:   led <= 1'b0;
               MODE_ON:    led <= 1'b1;
               MODE_PWM:   led <= (pwm_cnt < duty_act);
               MODE_BLINK: led <= (pwm_cnt < duty_act) && blink;
               default:    led <= 1'b0;
            endcase
         end
      end
   end

   assign rdata = {mode, duty};

endmodule

// File: rtl/wb_pwm_leds.sv
// Wishbone slave with a CTRL register and CH PWM LED channels sharing one timebase.
module wb_pwm_leds
   import wb_pwm_leds_pkg::*;
#(
   parameter int              WORD      = 16,
   parameter int              CH        = 8,
   parameter int              ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE    = 16'h0040,
   parameter int              BLINK_BIT = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [WORD/8-1:0] sel_i,
   input  logic [WORD-1:0]   dat_i,
   output logic              ack_o,
   output logic [WORD-1:0]   dat_o,
   output logic [CH-1:0]     leds_o
);

   localparam int OFS_W = $clog2(CH + 1);

   logic             hit;
   logic             req;
   logic             wr;
   logic [OFS_W-1:0] off;
   logic             en;
   logic [7:0]       presc;
   logic [7:0]       presc_cnt;
   logic [7:0]       pwm_cnt;
   logic [BLINK_BIT:0] per_cnt;
   logic             tick;
   logic             wrap;
   logic [WORD-1:0]  rdata;
   logic [MODE_LSB+1:0] ch_rdata [CH];

   assign hit  = (adr_i[ADDR_W-1:OFS_W] == BASE[ADDR_W-1:OFS_W]);
   assign off  = adr_i[OFS_W-1:0];
   assign req  = cyc_i & stb_i & hit & ~ack_o;
   assign wr   = req & we_i;
   assign tick = en && (presc_cnt == presc);
   assign wrap = tick && (pwm_cnt == 8'hFF);

   always_comb begin
      rdata = '0;
      if (off == OFS_W'(CTRL_OFS)) begin
         rdata[EN_BIT]          = en;
         rdata[PRESC_LSB +: 8]  = presc;
      end
      for (int k = 0; k < CH; k++) begin
         if (off == OFS_W'(k + 1)) rdata[MODE_LSB+1:0] = ch_rdata[k];
      end
   end

   // Only the low period-counter bits up to the blink tap are observable, so only those are kept.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ack_o     <= 1'b0;
         dat_o     <= '0;
         en        <= 1'b0;
         presc     <= '0;
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         per_cnt   <= '0;
      end else begin
         ack_o <= req;
         dat_o <= req ? rdata : '0;
         if (wr && (off == OFS_W'(CTRL_OFS))) begin
            if (sel_i[0]) en    <= dat_i[EN_BIT];
            if (sel_i[1]) presc <= dat_i[PRESC_LSB +: 8];
         end
         if (!en) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            per_cnt   <= '0;
         end else begin
            // a count already above a lowered presc runs on and wraps at 255
            presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
            if (wrap) per_cnt <= per_cnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_chan
      wb_pwm_chan u_chan (
         .clk_sys (clk_i),
         .rst_b   (rst_ni),
         .wr      (wr && (off == OFS_W'(k + 1))),
         .sel     (sel_i[1:0]),
         .dat     (dat_i[MODE_LSB+1:0]),
         .pwm_cnt (pwm_cnt),
         .wrap    (wrap),
         .blink   (per_cnt[BLINK_BIT]),
         .en      (en),
         .rdata   (ch_rdata[k]),
         .led     (leds_o[k])
      );
   end

endmodule

// File: tb/tb_wb_pwm_leds.sv
// Self-checking bench: directed scenarios plus random bus traffic against a behavioural model.
module tb_wb_pwm_leds;

   localparam int          CH     = 4;
   localparam int          BB     = 0;
   localparam int          OFS_W  = $clog2(CH + 1);
   localparam logic [15:0] BASE   = 16'h0040;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [15:0] adr;
   logic [1:0]  sel;
   logic [15:0] dat;
   logic        ack;
   logic [15:0] dat_o;
   logic [CH-1:0] leds;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit chk_en = 1'b0;

   // model state
   bit          m_en;
   int          m_presc, m_pc, m_ticks;
   int          m_duty [CH];
   int          m_mode [CH];
   int          m_act  [CH];
   bit          m_ack;
   logic [15:0] m_dat;
   logic [CH-1:0] m_leds;

   always #5 clk = ~clk;

   wb_pwm_leds #(
      .WORD(16), .CH(CH), .ADDR_W(16), .BASE(BASE), .BLINK_BIT(BB)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
      .adr_i(adr), .sel_i(sel), .dat_i(dat), .ack_o(ack), .dat_o(dat_o), .leds_o(leds)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: one update per rising edge from the pre-edge inputs and state.
   always @(posedge clk) begin : model
      logic [CH-1:0] ln;
      logic [15:0]   rd;
      bit            hit, req, wrapv;
      int            off, pwm, per;
      if (!rst_n) begin
         m_en = 0; m_presc = 0; m_pc = 0; m_ticks = 0;
         m_ack = 0; m_dat = '0; m_leds = '0;
         for (int k = 0; k < CH; k++) begin
            m_duty[k] = 0; m_mode[k] = 0; m_act[k] = 0;
         end
      end else begin
         hit = ((int'(adr) >> OFS_W) == (int'(BASE) >> OFS_W));
         off = int'(adr) % (1 << OFS_W);
         req = cyc && stb && hit && !m_ack;
         pwm = m_ticks % 256;
         per = m_ticks / 256;
         for (int k = 0; k < CH; k++) begin
            case (m_mode[k])
               1:       ln[k] = m_en;
               2:       ln[k] = m_en && (pwm < m_act[k]);
               3:       ln[k] = m_en && (pwm < m_act[k]) && (((per >> BB) & 1) == 1);
               default: ln[k] = 1'b0;
            endcase
         end
         rd = '0;
         if (off == 0) rd = 16'(m_presc * 256 + int'(m_en));
         else if (off <= CH) rd = 16'(m_mode[off-1] * 256 + m_duty[off-1]);
         wrapv = 0;
         if (!m_en) begin
            m_pc = 0; m_ticks = 0;
         end else if (m_pc == m_presc) begin
            m_pc = 0; m_ticks++; wrapv = ((m_ticks % 256) == 0);
         end else begin
            m_pc = (m_pc + 1) % 256;
         end
         for (int k = 0; k < CH; k++) if (wrapv || !m_en) m_act[k] = m_duty[k];
         if (req && we) begin
            if (off == 0) begin
               if (sel[0]) m_en = dat[0];
               if (sel[1]) m_presc = int'(dat[15:8]);
            end else if (off <= CH) begin
               if (sel[0]) m_duty[off-1] = int'(dat[7:0]);
               if (sel[1]) m_mode[off-1] = int'(dat[9:8]);
            end
         end
         m_ack  = req;
         m_dat  = req ? rd : 16'h0;
         m_leds = ln;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_ack", 32'(ack), 32'(m_ack));
         check("cyc_dat", 32'(dat_o), 32'(m_dat));
         check("cyc_leds", 32'(leds), 32'(m_leds));
      end
   end

   task automatic bus(input bit w, input logic [15:0] a, input logic [1:0] s, input logic [15:0] d,
                      input int maxw, output logic [15:0] rd, output int lat);
      @(negedge clk);
      cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
      lat = -1; rd = '0;
      for (int n = 1; n <= maxw; n++) begin
         @(negedge clk);
         if (ack) begin
            lat = n; rd = dat_o;
            break;
         end
      end
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic rd16(input logic [15:0] a, input logic [15:0] exp, input string name);
      logic [15:0] rd; int lat;
      bus(1'b0, a, 2'b11, 16'h0, 4, rd, lat);
      check({name, "_lat"}, 32'(lat), 32'd1);
      check(name, 32'(rd), 32'(exp));
   endtask

   task automatic wr16(input logic [15:0] a, input logic [1:0] s, input logic [15:0] d, input string name);
      logic [15:0] rd; int lat;
      bus(1'b1, a, s, d, 4, rd, lat);
      check({name, "_lat"}, 32'(lat), 32'd1);
   endtask

   // Wait for the negedge whose LED output reflects pwm count 0 of a period with the given blink parity.
   task automatic align(input int parity, input string name);
      bit found = 0;
      for (int n = 0; n < 1200; n++) begin
         @(negedge clk);
         if ((m_ticks % 256) == 1 && (parity < 0 || ((m_ticks / 256) % 2) == parity)) begin
            found = 1;
            break;
         end
      end
      if (!found) check({name, "_align_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int cnt_a, cnt_b, lat, r;
      logic [15:0] rd;

      rst_n = 0; cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; dat = '0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      @(negedge clk);
      rst_n = 1;

      // reset values
      for (int a = 0; a <= CH; a++) rd16(16'(16'h0040 + a), 16'h0, "rst_read");

      // decode
      wr16(16'h0045, 2'b11, 16'hFFFF, "wr_unmapped");
      rd16(16'h0045, 16'h0, "rd_unmapped");
      bus(1'b1, 16'h0080, 2'b11, 16'hFFFF, 10, rd, lat);
      check("miss_noack", 32'(lat), 32'hFFFF_FFFF);
      rd16(16'h0040, 16'h0, "ctrl_after_miss");

      // pwm, duty 64, presc 0
      wr16(16'h0040, 2'b11, 16'h0001, "wr_ctrl");
      wr16(16'h0041, 2'b11, 16'h0240, "wr_ch0");
      repeat (300) @(negedge clk);
      cnt_a = 0;
      for (int n = 0; n < 256; n++) begin
         @(negedge clk);
         if (leds[0]) cnt_a++;
      end
      check("pwm64_high", 32'(cnt_a), 32'd64);

      // shadowed duty change mid-period
      align(-1, "shadow");
      cnt_a = 0; cnt_b = 0;
      fork
         begin
            if (leds[0]) cnt_a++;
            for (int n = 1; n < 256; n++) begin
               @(negedge clk);
               if (leds[0]) cnt_a++;
            end
            for (int n = 0; n < 256; n++) begin
               @(negedge clk);
               if (leds[0]) cnt_b++;
            end
         end
         begin
            repeat (100) @(negedge clk);
            wr16(16'h0041, 2'b11, 16'h02C0, "wr_ch0_c0");
            rd16(16'h0041, 16'h02C0, "rd_ch0_c0");
         end
      join
      check("shadow_cur", 32'(cnt_a), 32'd64);
      check("shadow_next", 32'(cnt_b), 32'd192);

      // blink with duty 255
      wr16(16'h0042, 2'b11, 16'h03FF, "wr_ch1");
      repeat (300) @(negedge clk);
      align(1, "blink");
      cnt_a = 0; cnt_b = 0;
      if (leds[1]) cnt_a++;
      for (int n = 1; n < 256; n++) begin
         @(negedge clk);
         if (leds[1]) cnt_a++;
      end
      for (int n = 0; n < 256; n++) begin
         @(negedge clk);
         if (leds[1]) cnt_b++;
      end
      check("blink_odd", 32'(cnt_a), 32'd255);
      check("blink_even", 32'(cnt_b), 32'd0);

      // byte selects, then disable
      wr16(16'h0043, 2'b11, 16'h0080, "wr_ch2");
      wr16(16'h0043, 2'b10, 16'h0300, "wr_ch2_hi");
      rd16(16'h0043, 16'h0380, "rd_ch2_sel");
      wr16(16'h0040, 2'b01, 16'h0000, "wr_dis");
      @(negedge clk);
      check("dis_leds", 32'(leds), 32'd0);
      rd16(16'h0040, 16'h0000, "rd_ctrl_dis");

      // random traffic
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 599) != 0);
         cyc = ($urandom_range(0, 3) != 0);
         stb = cyc && ($urandom_range(0, 2) != 0);
         we  = $urandom_range(0, 1);
         r   = $urandom_range(0, 15);
         adr = (r < 14) ? 16'(16'h0040 + (r % 8)) : ((r == 14) ? 16'h0080 : 16'h003F);
         sel = 2'($urandom_range(0, 3));
         dat = 16'($urandom);
         if (adr == 16'h0040) begin
            dat[15:8] = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            dat[0]    = ($urandom_range(0, 7) != 0);
         end
      end
      @(negedge clk);
      rst_n = 1; cyc = 0; stb = 0; we = 0;
      repeat (5) @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
